// File: rtl/autocorr_sequencer_if.sv
// Bundle of the sequencer's stream, correlator and result handshakes.
// master = sequencer side, slave = surrounding datapath / testbench side.
interface autocorr_sequencer_if #(
  parameter int WIDTH = 5,
  parameter int LAG_W = 3,
  parameter int RES_W = 3
);
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [WIDTH-1:0] word_out;
  logic             corr_start;
  logic [LAG_W-1:0] corr_lag;
  logic             corr_done;
  logic [RES_W-1:0] corr_result;
  logic             res_valid;
  logic             res_ready;
  logic [LAG_W-1:0] res_lag;
  logic [RES_W-1:0] res_data;
  logic             res_err;
  logic             frame_done;
  logic             busy;

  modport master (
    input  bit_in, bit_valid, corr_done, corr_result, res_ready,
    output bit_ready, word_out, corr_start, corr_lag,
           res_valid, res_lag, res_data, res_err, frame_done, busy
  );

  modport slave (
    output bit_in, bit_valid, corr_done, corr_result, res_ready,
    input  bit_ready, word_out, corr_start, corr_lag,
           res_valid, res_lag, res_data, res_err, frame_done, busy
  );
endinterface

// File: rtl/autocorr_sequencer.sv
// Captures WIDTH-bit serial frames, then walks the shared correlator through
// lags 0..WIDTH-1, presenting each result on a valid/ready handshake.
module autocorr_sequencer #(
  parameter int WIDTH   = 5,
  parameter int LAG_W   = 3,
  parameter int RES_W   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  autocorr_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {CAPTURE, ISSUE, WAIT, PRESENT} state_t;

  typedef struct packed {
    logic [LAG_W-1:0] lag;
    logic [RES_W-1:0] data;
    logic             err;
  } res_t;

  state_t           state, state_nxt;
  logic [LAG_W-1:0] idx;
  logic [LAG_W-1:0] lag;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] frame_nxt;
  logic [WIDTH-1:0] word_q;
  logic [CNT_W-1:0] cnt;
  res_t             res_q;
  logic             res_valid_q;
  logic             frame_done_q;
  logic             last_idx;
  logic             last_lag;
  logic             expire;

  assign last_idx = (idx == '0);
  assign last_lag = (lag == LAG_W'(WIDTH - 1));
  // Expiry fires on the cycle the counter would step onto TIMEOUT.
  assign expire   = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    frame_nxt      = shreg;
    frame_nxt[idx] = bus.bit_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CAPTURE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CAPTURE: if (bus.bit_valid && last_idx) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.corr_done || expire) state_nxt = PRESENT;
      PRESENT: if (bus.res_ready) state_nxt = last_lag ? CAPTURE : ISSUE;
      default: state_nxt = CAPTURE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= LAG_W'(WIDTH - 1);
      lag          <= '0;
      shreg        <= '0;
      word_q       <= '0;
      cnt          <= '0;
      res_q        <= '0;
      res_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        CAPTURE: if (bus.bit_valid) begin
          shreg <= frame_nxt;
          if (last_idx) begin
            word_q <= frame_nxt;
            lag    <= '0;
            idx    <= LAG_W'(WIDTH - 1);
          end else begin
            idx <= idx - 1'b1;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          // A done coinciding with expiry still counts as a real result.
          if (bus.corr_done) begin
            res_q       <= '{lag: lag, data: bus.corr_result, err: 1'b0};
            res_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (expire) begin
              res_q       <= '{lag: lag, data: '0, err: 1'b1};
              res_valid_q <= 1'b1;
            end
          end
        end
        PRESENT: if (bus.res_ready) begin
          res_valid_q <= 1'b0;
          if (last_lag) frame_done_q <= 1'b1;
          else          lag          <= lag + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.bit_ready  = (state == CAPTURE);
  assign bus.busy       = (state != CAPTURE);
  assign bus.corr_start = (state == ISSUE);
  assign bus.corr_lag   = lag;
  assign bus.word_out   = word_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_lag    = res_q.lag;
  assign bus.res_data   = res_q.data;
  assign bus.res_err    = res_q.err;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_autocorr_sequencer.sv
// Directed bench: frame capture, per-lag sequencing, backpressure, timeout,
// gapped capture and mid-frame reset, with hand-derived expectations.
module tb_autocorr_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  autocorr_sequencer_if #(.WIDTH(5), .LAG_W(3), .RES_W(3)) bus_if ();

  autocorr_sequencer #(.WIDTH(5), .LAG_W(3), .RES_W(3), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Feed five consecutive valid bits MSB first; word_out must hold until the last.
  task automatic send(input logic [4:0] v, input logic [4:0] prev);
    for (int i = 4; i >= 0; i--) begin
      bus_if.bit_valid = 1'b1;
      bus_if.bit_in    = v[i];
      if (i == 0) chk("word_hold", bus_if.word_out, prev);
      step();
    end
    bus_if.bit_valid = 1'b0;
    chk("word_out", bus_if.word_out, v);
    chk("busy_issue", bus_if.busy, 1);
    chk("bit_ready_issue", bus_if.bit_ready, 0);
  endtask

  // From the ISSUE cycle: answer with done dly cycles after start, result lag+1.
  task automatic lag_ok(input int l, input int dly);
    chk("corr_start", bus_if.corr_start, 1);
    chk("corr_lag", bus_if.corr_lag, l);
    repeat (dly) step();
    bus_if.corr_done   = 1'b1;
    bus_if.corr_result = 3'(l + 1);
    step();
    bus_if.corr_done = 1'b0;
    chk("res_valid", bus_if.res_valid, 1);
    chk("res_lag", bus_if.res_lag, l);
    chk("res_data", bus_if.res_data, l + 1);
    chk("res_err", bus_if.res_err, 0);
  endtask

  task automatic accept(input int l);
    bus_if.res_ready = 1'b1;
    step();
    chk("res_valid_drop", bus_if.res_valid, 0);
    chk("frame_done", bus_if.frame_done, (l == 4) ? 1 : 0);
    if (l == 4) begin
      chk("bit_ready_after_frame", bus_if.bit_ready, 1);
      step();
      chk("frame_done_pulse", bus_if.frame_done, 0);
    end
  endtask

  logic       gv [13];
  logic       gb [13];

  initial begin
    bus_if.bit_in = 1'b0;  bus_if.bit_valid = 1'b0;
    bus_if.corr_done = 1'b0;  bus_if.corr_result = '0;
    bus_if.res_ready = 1'b1;
    step(); step();
    // reset state
    chk("rst_bit_ready", bus_if.bit_ready, 1);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_word", bus_if.word_out, 0);
    chk("rst_corr_start", bus_if.corr_start, 0);
    chk("rst_corr_lag", bus_if.corr_lag, 0);
    chk("rst_res_valid", bus_if.res_valid, 0);
    chk("rst_frame_done", bus_if.frame_done, 0);
    rst_n = 1'b1;
    step();

    // frame A: capture then full lag sweep with done latency 2
    send(5'b10110, 5'b00000);
    for (int l = 0; l < 5; l++) begin lag_ok(l, 2); accept(l); end

    // frame B: backpressure at lag 2
    send(5'b01101, 5'b10110);
    for (int l = 0; l < 5; l++) begin
      if (l == 2) bus_if.res_ready = 1'b0;
      lag_ok(l, 2);
      if (l == 2) begin
        for (int k = 0; k < 10; k++) begin
          chk("hold_vld", bus_if.res_valid, 1);
          chk("hold_lag_data", {bus_if.res_lag, bus_if.res_data, bus_if.res_err}, {3'd2, 3'd3, 1'b0});
          chk("hold_no_start", bus_if.corr_start, 0);
          step();
        end
      end
      accept(l);
    end

    // frame C: timeout at lag 1, done coincident with expiry at lag 3
    send(5'b11100, 5'b01101);
    lag_ok(0, 2); accept(0);
    chk("to_start", bus_if.corr_start, 1);
    chk("to_lag", bus_if.corr_lag, 1);
    bus_if.corr_result = 3'd7;
    step();
    for (int k = 0; k < 15; k++) begin
      chk("to_wait", bus_if.res_valid, 0);
      step();
    end
    chk("to_valid", bus_if.res_valid, 1);
    chk("to_err", bus_if.res_err, 1);
    chk("to_data", bus_if.res_data, 0);
    chk("to_lag_res", bus_if.res_lag, 1);
    accept(1);
    lag_ok(2, 2); accept(2);
    lag_ok(3, 15); accept(3);
    lag_ok(4, 2); accept(4);

    // frame D: gapped capture, then bits driven while busy must be ignored
    gv = '{1,0,0,1,0,0,1,0,0,1,0,0,1};
    gb = '{1,0,0,1,1,1,0,1,0,0,1,0,1};
    for (int i = 0; i < 13; i++) begin
      bus_if.bit_valid = gv[i];
      bus_if.bit_in    = gb[i];
      if (i == 12) chk("gap_word_hold", bus_if.word_out, 5'b11100);
      step();
    end
    chk("gap_word", bus_if.word_out, 5'b11001);
    bus_if.bit_valid = 1'b1;
    bus_if.bit_in    = 1'b1;
    for (int l = 0; l < 5; l++) begin
      chk("busy_no_ready", bus_if.bit_ready, 0);
      lag_ok(l, 1);
      if (l == 4) bus_if.bit_valid = 1'b0;
      accept(l);
    end
    chk("word_held", bus_if.word_out, 5'b11001);

    // frame E: reset during WAIT at lag 3, late done ignored, fresh frame F
    send(5'b10011, 5'b11001);
    for (int l = 0; l < 3; l++) begin lag_ok(l, 2); accept(l); end
    chk("e_start3", bus_if.corr_start, 1);
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("ar_bit_ready", bus_if.bit_ready, 1);
    chk("ar_busy", bus_if.busy, 0);
    chk("ar_word", bus_if.word_out, 0);
    chk("ar_corr_lag", bus_if.corr_lag, 0);
    chk("ar_res", {bus_if.res_valid, bus_if.res_lag, bus_if.res_data, bus_if.res_err}, 0);
    step();
    rst_n = 1'b1;
    bus_if.corr_done   = 1'b1;
    bus_if.corr_result = 3'd5;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("late_done_vld", bus_if.res_valid, 0);
      chk("late_done_busy", bus_if.busy, 0);
    end
    bus_if.corr_done = 1'b0;
    send(5'b01011, 5'b00000);
    chk("f_start", bus_if.corr_start, 1);
    chk("f_lag", bus_if.corr_lag, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
